ladowarka_prog: RTL and testbench
=================================

LADOWARKA_PROG -- requirements
Module: ladowarka_prog

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: program memory address width.
REQ-002 Parameter DATA_WIDTH, default 15: instruction word width; only value 15 supported.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load; ignored while busy.
REQ-006 len_m1  input  ADDR_WIDTH  number of words to load minus one; sampled on accepted start.
REQ-007 in_data  input  8  byte stream from host link.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts byte; transfer when in_valid && in_ready.
REQ-010 we_o  output  1  program memory write strobe.
REQ-011 waddr_o  output  ADDR_WIDTH  program memory write address.
REQ-012 wdata_o  output  DATA_WIDTH  program memory write data.
REQ-013 busy  output  1  load in progress; also CPU hold request.
REQ-014 done  output  1  one-cycle pulse at load end.
REQ-015 err  output  1  checksum mismatch flag; sticky until next accepted start.

Function
REQ-016 FSM states IDLE, HI, LO, WRITE, CSUM, FIN, registered.
REQ-017 IDLE: start=1 -> HI; word counter cleared to 0, len_m1 latched, err cleared, checksum cleared.
REQ-018 in_ready=1 only in HI, LO, CSUM; 0 in IDLE, WRITE, FIN.
REQ-019 HI: accepted byte stored as word bits [14:8] = in_data[6:0]; in_data[7] ignored; -> LO.
REQ-020 LO: accepted byte stored as bits [7:0]; -> WRITE.
REQ-021 WRITE: we_o=1 for exactly this one cycle, waddr_o=word counter, wdata_o=assembled word; latency one cycle after LO handshake.
REQ-022 WRITE exit: counter != len_m1 -> counter+1, -> HI; counter == len_m1 -> CSUM if checksum enabled, else FIN; counter never wraps.
REQ-023 in_valid low in HI/LO/CSUM: state holds, no write.
REQ-024 FIN: done=1 for one cycle -> IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 we_o=0 outside WRITE; waddr_o/wdata_o hold last written values.
REQ-027 start while busy has no effect; start coincident with FIN ignored.

Reset
REQ-028 rst_n=0 at a clock edge: state IDLE, counter 0, we_o 0, in_ready 0, busy 0, done 0, err 0, waddr_o 0, wdata_o 0, checksum 0.
REQ-029 Reset mid-load aborts with no further writes; already-written words are not undone; next start restarts at address 0.

Configuration
REQ-030 Macro LADOWARKA_CSUM_EN defined: checksum = XOR of all accepted data bytes (full 8 bits incl. bit 7); after last word one extra byte accepted in CSUM; mismatch sets err in the cycle entering FIN, visible with done.
REQ-031 Macro undefined: CSUM state and checksum register absent; WRITE of last word -> FIN; err tied to 0.

Structure
REQ-032 Package ladowarka_pkg holds state enum type and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-033 Single module, no sub-modules; byte-to-word assembly inline.

Verification
REQ-034 len_m1=0, bytes 0x12,0x34 -> one cycle after second handshake we_o=1, waddr_o=0x00, wdata_o=0x1234; done pulse next cycle; exactly one write.
REQ-035 len_m1=2, bytes 0x81,0x00,0x02,0x55,0x7F,0xFF with random in_valid gaps -> writes (0x00,0x0100),(0x01,0x0255),(0x02,0x7FFF) in order, no writes during gaps.
REQ-036 LADOWARKA_CSUM_EN, len_m1=0, bytes 0x01,0x02, csum 0x03 -> done with err=0; repeat with csum 0x04 -> done with err=1; next start clears err.
REQ-037 len_m1=0xFF, 512 bytes -> 256 writes, addresses 0x00..0xFF, last waddr_o=0xFF, single done pulse.
REQ-038 rst_n=0 after 3 bytes accepted -> no further we_o, busy=0, in_ready=0; next start with len_m1=0 writes address 0x00.
REQ-039 start pulsed during HI with len_m1=5 -> ignored; load completes with original length.

Source files
------------

// File: rtl/ladowarka_pkg.sv
// Shared types and defaults for the program-memory loader.
// LADOWARKA_CSUM_EN adds the trailing checksum byte state.
package ladowarka_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 15;

`ifdef LADOWARKA_CSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_FIN   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_FIN   = 3'd5
   } state_t;
`endif

   // Running XOR checksum over accepted link bytes.
   function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/ladowarka_prog.sv
// Byte-stream to 15-bit program memory loader; holds the CPU via busy while loading.
// Optional checksum trailer byte enabled by macro LADOWARKA_CSUM_EN.
module ladowarka_prog
   import ladowarka_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] len_m1,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                state_r, state_s;
   logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
   logic [ADDR_WIDTH-1:0] len_r, len_s;
   logic [ADDR_WIDTH-1:0] waddr_r, waddr_s;
   logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
   logic [6:0]            hi_r, hi_s;
   logic                  in_ready_r, in_ready_s;
   logic                  we_r, we_s;
   logic                  busy_r, busy_s;
   logic                  done_r, done_s;
`ifdef LADOWARKA_CSUM_EN
   logic [7:0]            csum_r, csum_s;
   logic                  err_r, err_s;
`endif

   // Next-state and next-output decode; all outputs are registered from these.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      len_s   = len_r;
      waddr_s = waddr_r;
      wdata_s = wdata_r;
      hi_s    = hi_r;
`ifdef LADOWARKA_CSUM_EN
      csum_s  = csum_r;
      err_s   = err_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_HI;
               cnt_s   = {ADDR_WIDTH{1'b0}};
               len_s   = len_m1;
`ifdef LADOWARKA_CSUM_EN
               csum_s  = 8'h00;
               err_s   = 1'b0;
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HI: begin
            // Bit 7 of the high byte does not reach the 15-bit word.
            if (in_valid) begin
               hi_s    = in_data[6:0];
               state_s = ST_LO;
`ifdef LADOWARKA_CSUM_EN
               csum_s  = csum_step(csum_r, in_data);
`endif
            end else begin
               state_s = ST_HI;
            end
         end
         ST_LO: begin
            if (in_valid) begin
               wdata_s = {hi_r, in_data};
               waddr_s = cnt_r;
               state_s = ST_WRITE;
`ifdef LADOWARKA_CSUM_EN
               csum_s  = csum_step(csum_r, in_data);
`endif
            end else begin
               state_s = ST_LO;
            end
         end
         ST_WRITE: begin
            if (cnt_r != len_r) begin
               cnt_s   = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
               state_s = ST_HI;
            end else begin
`ifdef LADOWARKA_CSUM_EN
               state_s = ST_CSUM;
`else
               state_s = ST_FIN;
`endif
            end
         end
`ifdef LADOWARKA_CSUM_EN
         ST_CSUM: begin
            if (in_valid) begin
               err_s   = (csum_r != in_data);
               state_s = ST_FIN;
            end else begin
               state_s = ST_CSUM;
            end
         end
`endif
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      in_ready_s = (state_s == ST_HI) || (state_s == ST_LO)
`ifdef LADOWARKA_CSUM_EN
                   || (state_s == ST_CSUM)
`endif
                   ;
      we_s   = (state_s == ST_WRITE);
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_FIN);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {ADDR_WIDTH{1'b0}};
         len_r      <= {ADDR_WIDTH{1'b0}};
         waddr_r    <= {ADDR_WIDTH{1'b0}};
         wdata_r    <= {DATA_WIDTH{1'b0}};
         hi_r       <= 7'd0;
         in_ready_r <= 1'b0;
         we_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
`ifdef LADOWARKA_CSUM_EN
         csum_r     <= 8'h00;
         err_r      <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         len_r      <= len_s;
         waddr_r    <= waddr_s;
         wdata_r    <= wdata_s;
         hi_r       <= hi_s;
         in_ready_r <= in_ready_s;
         we_r       <= we_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
`ifdef LADOWARKA_CSUM_EN
         csum_r     <= csum_s;
         err_r      <= err_s;
`endif
      end
   end

   assign in_ready = in_ready_r;
   assign we_o     = we_r;
   assign waddr_o  = waddr_r;
   assign wdata_o  = wdata_r;
   assign busy     = busy_r;
   assign done     = done_r;
`ifdef LADOWARKA_CSUM_EN
   assign err      = err_r;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ladowarka_prog.sv
// Scoreboard bench for ladowarka_prog: expected writes/done pushed by stimulus, popped by a monitor.
module tb_ladowarka_prog;

   typedef struct packed {
      logic [7:0]  a;
      logic [14:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len_m1;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        we_o;
   logic [7:0]  waddr_o;
   logic [14:0] wdata_o;
   logic        busy;
   logic        done;
   logic        err;

   wr_t  exp_wr[$];
   logic exp_done[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wr_count = 0;
   int   done_count = 0;
   logic [7:0] cs;

   ladowarka_prog #(.ADDR_WIDTH(8), .DATA_WIDTH(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Monitor: every write and every done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (we_o === 1'b1) begin
         wr_count++;
         n_checks++;
         if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got addr=%h data=%h, none expected", waddr_o, wdata_o);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            if (waddr_o !== e.a || wdata_o !== e.d) begin
               n_fail++;
               $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h",
                        waddr_o, wdata_o, e.a, e.d);
            end
         end
      end
      if (done === 1'b1) begin
         done_count++;
         n_checks++;
         if (exp_done.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done err=%b", err);
         end else begin
            logic ee;
            ee = exp_done.pop_front();
            if (err !== ee) begin
               n_fail++;
               $display("FAIL done_err got %b, expected %b", err, ee);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string name);
      chk({name, "_we"}, {31'd0, we_o}, 32'd0);
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_done"}, {31'd0, done}, 32'd0);
      chk({name, "_err"}, {31'd0, err}, 32'd0);
      chk({name, "_waddr"}, {24'd0, waddr_o}, 32'd0);
      chk({name, "_wdata"}, {17'd0, wdata_o}, 32'd0);
   endtask

   task automatic do_start(input logic [7:0] len);
      start  = 1'b1;
      len_m1 = len;
      cs     = 8'h00;
      @(posedge clk); #1;
      start  = 1'b0;
      len_m1 = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         t++;
         if (t > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout got 0, expected 1 within 100 cycles");
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cs = cs ^ b;
   endtask

   // Send one word: the write is expected only once its low byte is on the way.
   task automatic send_word(input logic [7:0] addr, input logic [7:0] hi, input logic [7:0] lo, input int gap);
      wr_t e;
      send_byte(hi, gap);
      e.a = addr;
      e.d = {hi[6:0], lo};
      exp_wr.push_back(e);
      send_byte(lo, gap);
   endtask

   task automatic finish_load(input logic bad);
      exp_done.push_back(bad);
`ifdef LADOWARKA_CSUM_EN
      begin
         logic [7:0] c;
         c = bad ? (cs ^ 8'h07) : cs;
         send_byte(c, 0);
      end
`endif
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) break;
         t++;
         if (t > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout got no done, expected done within 50 cycles", name);
            break;
         end
      end
      @(posedge clk); #1;
      chk({name, "_queue_empty"}, exp_wr.size(), 32'd0);
   endtask

   initial begin
      int w0;
      int d0;
      logic [7:0] hb;
      logic [7:0] lb;
      logic [7:0] v035 [6];
      rst_n = 1'b0; start = 1'b0; len_m1 = 8'h00; in_data = 8'h00; in_valid = 1'b0;
      v035[0] = 8'h81; v035[1] = 8'h00; v035[2] = 8'h02;
      v035[3] = 8'h55; v035[4] = 8'h7F; v035[5] = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // Single word load.
      w0 = wr_count;
      do_start(8'h00);
      chk("t034_busy", {31'd0, busy}, 32'd1);
      chk("t034_in_ready", {31'd0, in_ready}, 32'd1);
      send_word(8'h00, 8'h12, 8'h34, 0);
      chk("t034_we_after_lo", {31'd0, we_o}, 32'd1);
      finish_load(1'b0);
      wait_done("t034");
      chk("t034_write_count", wr_count - w0, 32'd1);
      chk("t034_idle_busy", {31'd0, busy}, 32'd0);

      // Three words with random in_valid gaps.
      do_start(8'h02);
      for (int i = 0; i < 3; i++)
         send_word(i[7:0], v035[2*i], v035[2*i+1], $urandom_range(0, 3));
      finish_load(1'b0);
      wait_done("t035");
      chk("t035_last_wdata", {17'd0, wdata_o}, 32'h7FFF);

`ifdef LADOWARKA_CSUM_EN
      // Checksum good, then bad, then cleared by the next start.
      do_start(8'h00);
      send_word(8'h00, 8'h01, 8'h02, 0);
      finish_load(1'b0);
      wait_done("t036_good");
      do_start(8'h00);
      send_word(8'h00, 8'h01, 8'h02, 0);
      finish_load(1'b1);
      wait_done("t036_bad");
      chk("t036_err_sticky", {31'd0, err}, 32'd1);
      do_start(8'h00);
      chk("t036_err_cleared", {31'd0, err}, 32'd0);
      send_word(8'h00, 8'h01, 8'h02, 0);
      finish_load(1'b0);
      wait_done("t036_after");
`endif

      // Full 256-word load.
      w0 = wr_count;
      do_start(8'hFF);
      for (int i = 0; i < 256; i++) begin
         hb = i[7:0] ^ 8'hA5;
         lb = ~i[7:0];
         send_word(i[7:0], hb, lb, 0);
      end
      finish_load(1'b0);
      d0 = done_count;
      wait_done("t037");
      repeat (3) @(posedge clk);
      #1;
      chk("t037_write_count", wr_count - w0, 32'd256);
      chk("t037_last_waddr", {24'd0, waddr_o}, 32'hFF);
      chk("t037_done_pulses", done_count - d0, 32'd1);

      // Reset after three accepted bytes.
      do_start(8'h01);
      send_word(8'h00, 8'h11, 8'h22, 0);
      send_byte(8'h33, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset("t038_reset");
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t038_busy_after", {31'd0, busy}, 32'd0);
      do_start(8'h00);
      send_word(8'h00, 8'h45, 8'h67, 0);
      finish_load(1'b0);
      wait_done("t038_restart");

      // Start during HI is ignored.
      w0 = wr_count;
      do_start(8'h01);
      start = 1'b1; len_m1 = 8'h05;
      @(posedge clk); #1;
      start = 1'b0; len_m1 = 8'h00;
      chk("t039_busy", {31'd0, busy}, 32'd1);
      send_word(8'h00, 8'hAA, 8'hBB, 1);
      send_word(8'h01, 8'h0C, 8'hDD, 0);
      finish_load(1'b0);
      wait_done("t039");
      repeat (10) @(posedge clk);
      #1;
      chk("t039_write_count", wr_count - w0, 32'd2);
      chk("t039_idle", {31'd0, busy}, 32'd0);
      chk("final_done_queue", exp_done.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
